serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
Parametrised bit-serial adder/subtractor, the multi-bit successor of the 1-bit enabled adder. Operand bits arrive LSB-first, one pair per enabled cycle. A single carry flip-flop ripples through time. After WIDTH bits the block presents a parallel result with unsigned carry/borrow and signed overflow flags, plus a one-cycle done pulse. It is intended for area-light arithmetic in datapath exercises and for serial-link checksum paths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin a new operation; the start cycle carries no operand data
sub  input  1  mode, sampled on start: 0 = A+B, 1 = A-B
en  input  1  qualifies a and b as valid operand bits this cycle
a  input  1  operand A bit, LSB first
b  input  1  operand B bit, LSB first
busy  output  1  high while an operation is collecting bits
done  output  1  one-cycle pulse; result outputs updated in the same cycle
sum  output  WIDTH  registered result, held until the next completion
carry_out  output  1  final carry; for subtraction 1 = no borrow
overflow  output  1  signed two's-complement overflow of the completed op

Behaviour:
- Reset (async, any time): state returns to IDLE. busy, done, sum, carry_out and overflow clear to 0. The internal shift register, carry flop, counter and mode flop clear to 0. An operation in flight is lost and produces no done.
- States: IDLE and RUN. busy is high exactly when the state is RUN.
- IDLE:
  - en, a and b are ignored.
  - On start: sub_r <= sub; carry <= sub, which supplies the +1 of two's complement; cnt <= 0; go to RUN.
- RUN, per cycle with en=1:
  - bi = b XOR sub_r
  - s = a XOR bi XOR carry
  - carry <= majority(a, bi, carry)
  - Shift register shifts right, inserting s at bit WIDTH-1.
  - cnt <= cnt+1
- RUN with en=0: full stall. No state, carry or counter changes.
- Completion, on the en cycle where cnt = WIDTH-1:
  - sum <= final shifted value, with the last s at the MSB.
  - carry_out <= carry out of the MSB.
  - overflow <= carry into MSB XOR carry out of MSB.
  - done <= 1 for exactly the next cycle.
  - Go to IDLE.
  - Latency: done is high in the cycle after the clock edge that captures the WIDTH-th enabled bit pair.
- start while in RUN: restart. The current op is aborted with no done, and the block re-initialises exactly as from IDLE. sum and flags keep their previous values.
- start in the same cycle as the completing en bit: completion takes priority. done pulses and the result is stored; start is ignored, so the caller re-issues it.
- done, sum, carry_out and overflow change only on completion or reset. done deasserts one cycle after it rises.
- All arithmetic is modulo 2^WIDTH. The counter is wide enough to hold WIDTH-1 with no wrap.

Test Plan:
- WIDTH=8, add, A=0x05, B=0x03, en continuous -> sum=0x08, carry_out=0, overflow=0. done is a single pulse in the cycle after the 8th en cycle, and busy falls with it.
- Add 0x7F+0x01 -> sum=0x80, carry_out=0, overflow=1. Add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0.
- Subtract 0x03-0x05 -> sum=0xFE, carry_out=0 (borrow), overflow=0. Subtract 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1.
- Add 0x5A+0x33 with random en=0 gaps (1-3 cycles) between bits -> sum=0x8D, overflow=1, carry_out=0. done arrives one cycle after the 8th enabled bit; sum and flags hold unchanged during the gaps.
- After 4 bits, assert start (sub=1), then feed 0x10-0x01 -> no done for the aborted op. Result sum=0x0F, carry_out=1, overflow=0. Previous sum is held until then.
- Assert reset asynchronously mid-operation, between clock edges, after 5 bits -> busy, done, sum and flags read 0 immediately. A following add of 0x01+0x01 yields sum=0x02.

Source files
------------

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: operand bits arrive LSB-first, one pair per enabled cycle,
// through a single carry flop; a parallel result with carry/overflow flags follows WIDTH bits.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             sub_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic             bi, s, c_nxt, last_bit;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // One full-adder slice; subtraction inverts B and relies on the carry preset to 1.
  always_comb begin
    bi       = b ^ sub_r;
    s        = a ^ bi ^ carry;
    c_nxt    = maj(a, bi, carry);
    last_bit = en && (cnt == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Completion outranks a coincident start; a start mid-run restarts without touching the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_r     <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sub_r <= sub;
            carry <= sub;
            cnt   <= '0;
            shreg <= '0;
          end
        end
        RUN: begin
          if (last_bit) begin
            sum       <= {s, shreg[WIDTH-1:1]};
            carry_out <= c_nxt;
            overflow  <= carry ^ c_nxt;
            done      <= 1'b1;
          end else if (start) begin
            sub_r <= sub;
            carry <= sub;
            cnt   <= '0;
            shreg <= '0;
          end else if (en) begin
            carry <= c_nxt;
            shreg <= {s, shreg[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n (WIDTH=8) with a result scoreboard fed from a word-level model.
module tb_serial_adder_n;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset, start, sub, en, a, b;
  logic             busy, done, carry_out, overflow;
  logic [WIDTH-1:0] sum;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } res_t;

  res_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [WIDTH-1:0] held_s;
  logic             held_c, held_o;

  serial_adder_n #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .en(en), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic sb_);
    res_t             r;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bo;
    bo     = sb_ ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, bo} + {{WIDTH{1'b0}}, sb_};
    r.s    = full[WIDTH-1:0];
    r.c    = full[WIDTH];
    r.o    = (av[WIDTH-1] == bo[WIDTH-1]) && (r.s[WIDTH-1] != av[WIDTH-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_sum"},  32'(sum), 32'(held_s));
    chk({tag, "_cout"}, 32'(carry_out), 32'(held_c));
    chk({tag, "_ovf"},  32'(overflow), 32'(held_o));
  endtask

  // abort_after/reset_after: -1 disables, otherwise the number of bits fed before acting.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sb_,
                        input int gaps_max, input int abort_after, input int reset_after,
                        input bit start_on_last);
    res_t r;
    @(negedge clk);
    start = 1'b1; sub = sb_; en = 1'b0;
    if (abort_after < 0 && reset_after < 0) sb.push_back(model(av, bv, sb_));
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'h1);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == abort_after) return;
      if (i == reset_after) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sum",  32'(sum), 32'h0);
        chk("rst_cout", 32'(carry_out), 32'h0);
        chk("rst_ovf",  32'(overflow), 32'h0);
        held_s = '0; held_c = 1'b0; held_o = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        en = 1'b0;
        return;
      end
      if (gaps_max > 0 && i > 0) begin
        repeat ($urandom_range(gaps_max, 1)) begin
          en = 1'b0;
          @(negedge clk);
          check_held("gap");
          chk("gap_busy", 32'(busy), 32'h1);
        end
      end
      en = 1'b1; a = av[i]; b = bv[i];
      start = start_on_last && (i == WIDTH - 1);
      @(negedge clk);
      if (i < WIDTH - 1) check_held("bit");
    end
    en = 1'b0; start = 1'b0;
    chk("done_pulse", 32'(done), 32'h1);
    chk("busy_fall", 32'(busy), 32'h0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'h1);
    end else begin
      r = sb.pop_front();
      chk("sum",  32'(sum), 32'(r.s));
      chk("cout", 32'(carry_out), 32'(r.c));
      chk("ovf",  32'(overflow), 32'(r.o));
      held_s = r.s; held_c = r.c; held_o = r.o;
    end
    @(negedge clk);
    chk("done_low", 32'(done), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    check_held("after");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0;
    held_s = '0; held_c = 1'b0; held_o = 1'b0;
    #2;
    chk("init_busy", 32'(busy), 32'h0);
    check_held("init");
    @(negedge clk);
    reset = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 0, -1, -1, 1'b0);
    chk("k_05p03", 32'(sum), 32'h08);
    run_op(8'h7F, 8'h01, 1'b0, 0, -1, -1, 1'b0);
    chk("k_7Fp01_ovf", 32'(overflow), 32'h1);
    run_op(8'hFF, 8'h01, 1'b0, 0, -1, -1, 1'b0);
    chk("k_FFp01_c", 32'(carry_out), 32'h1);
    run_op(8'h03, 8'h05, 1'b1, 0, -1, -1, 1'b0);
    chk("k_03m05", 32'(sum), 32'hFE);
    run_op(8'h80, 8'h01, 1'b1, 0, -1, -1, 1'b0);
    chk("k_80m01", 32'({sum, carry_out, overflow}), 32'({8'h7F, 1'b1, 1'b1}));
    run_op(8'h5A, 8'h33, 1'b0, 3, -1, -1, 1'b0);
    chk("k_5Ap33", 32'({sum, carry_out, overflow}), 32'({8'h8D, 1'b0, 1'b1}));

    run_op(8'hAA, 8'h11, 1'b0, 0, 4, -1, 1'b0);
    chk("abort_busy", 32'(busy), 32'h1);
    run_op(8'h10, 8'h01, 1'b1, 0, -1, -1, 1'b0);
    chk("k_10m01", 32'({sum, carry_out, overflow}), 32'({8'h0F, 1'b1, 1'b0}));

    run_op(8'h22, 8'h44, 1'b0, 0, -1, -1, 1'b1);
    chk("k_22p44", 32'(sum), 32'h66);

    run_op(8'h3C, 8'h0F, 1'b0, 0, -1, 5, 1'b0);
    run_op(8'h01, 8'h01, 1'b0, 0, -1, -1, 1'b0);
    chk("k_01p01", 32'(sum), 32'h02);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
